line_transfer_arbiter: RTL

//  Shares the single 32-bit block-RAM port behind the data cache between two line requesters
//  (port 0: data cache, port 1: instruction cache / second client).

---
 rtl/line_transfer_arbiter_if.sv | 37 +++
 rtl/line_transfer_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/line_transfer_arbiter_if.sv
// Line-transfer port bundle: two line requesters plus the shared 32-bit RAM port.
// The arbiter uses the slave modport; requesters and the RAM sit on the master side.
interface line_transfer_arbiter_if #(
   parameter int WORDS_PER_LINE = 4,
   parameter int WORDS_LOG      = 2,
   parameter int LINE_ADDR_W    = 8
);
   localparam int LINE_W = 32 * WORDS_PER_LINE;

   logic                             req0;
   logic                             req1;
   logic                             we0;
   logic                             we1;
   logic [LINE_ADDR_W-1:0]           line_addr0;
   logic [LINE_ADDR_W-1:0]           line_addr1;
   logic [LINE_W-1:0]                wdata0;
   logic [LINE_W-1:0]                wdata1;
   logic [1:0]                       gnt;
   logic                             done0;
   logic                             done1;
   logic [LINE_W-1:0]                rdata;
   logic                             busy;
   logic [LINE_ADDR_W+WORDS_LOG-1:0] mem_addr;
   logic                             mem_we;
   logic [31:0]                      mem_wdata;
   logic [31:0]                      mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, line_addr0, line_addr1, wdata0, wdata1, mem_rdata,
      output gnt, done0, done1, rdata, busy, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, line_addr0, line_addr1, wdata0, wdata1, mem_rdata,
      input  gnt, done0, done1, rdata, busy, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/line_transfer_arbiter.sv
// Round-robin owner of the cache block-RAM port; moves one line word-by-word per grant.
// Grant edge E0 -> done pulse after E(WORDS_PER_LINE+1); later requests wait, no preemption.
module line_transfer_arbiter #(
   parameter int WORDS_PER_LINE = 4,
   parameter int WORDS_LOG      = 2,
   parameter int LINE_ADDR_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   line_transfer_arbiter_if.slave bus
);
   localparam int LINE_W = 32 * WORDS_PER_LINE;
   localparam int MA_W   = LINE_ADDR_W + WORDS_LOG;
   localparam logic [WORDS_LOG-1:0] CNT_ONE  = WORDS_LOG'(1);
   localparam logic [WORDS_LOG-1:0] CNT_LAST = WORDS_LOG'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             gnt_q, gnt_d;
   logic                   last_gnt_q, last_gnt_d;
   logic                   done0_q, done0_d;
   logic                   done1_q, done1_d;
   logic                   busy_q, busy_d;
   logic                   we_q, we_d;
   logic [LINE_ADDR_W-1:0] line_q, line_d;
   logic [LINE_W-1:0]      wdata_q, wdata_d;
   logic [WORDS_LOG-1:0]   cnt_q, cnt_d;
   logic [MA_W-1:0]        mem_addr_q, mem_addr_d;
   logic                   mem_we_q, mem_we_d;
   logic [31:0]            mem_wdata_q, mem_wdata_d;
   logic [LINE_W-1:0]      rdata_q, rdata_d;

   logic                   win1;
   logic                   cap_en;
   logic [WORDS_LOG-1:0]   cap_idx;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_gnt_d  = last_gnt_q;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      busy_d      = busy_q;
      we_d        = we_q;
      line_d      = line_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      win1        = 1'b0;

      // The read for the word presented in cycle k returns during cycle k+1; the
      // counter wraps on the last XFER edge, so cnt-1 also names the word in DRAIN.
      cap_idx = cnt_q - CNT_ONE;
      cap_en  = !we_q && ((state_q == XFER && cnt_q != '0) || state_q == DRAIN);
      if (cap_en) begin
         rdata_d[{cap_idx, 5'd0} +: 32] = bus.mem_rdata;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               win1        = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
               gnt_d       = win1 ? 2'b10 : 2'b01;
               last_gnt_d  = win1;
               busy_d      = 1'b1;
               we_d        = win1 ? bus.we1 : bus.we0;
               line_d      = win1 ? bus.line_addr1 : bus.line_addr0;
               wdata_d     = win1 ? bus.wdata1 : bus.wdata0;
               cnt_d       = '0;
               mem_addr_d  = {line_d, {WORDS_LOG{1'b0}}};
               mem_we_d    = we_d;
               mem_wdata_d = wdata_d[31:0];
               state_d     = XFER;
            end
         end
         XFER: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = DRAIN;
            end else begin
               mem_addr_d  = {line_q, cnt_d};
               mem_we_d    = we_q;
               mem_wdata_d = wdata_q[{cnt_d, 5'd0} +: 32];
            end
         end
         DRAIN: begin
            done0_d = gnt_q[0];
            done1_d = gnt_q[1];
            state_d = DONE;
         end
         DONE: begin
            gnt_d   = 2'b00;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= 2'b00;
         last_gnt_q  <= 1'b1;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         busy_q      <= 1'b0;
         we_q        <= 1'b0;
         line_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         last_gnt_q  <= last_gnt_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         busy_q      <= busy_d;
         we_q        <= we_d;
         line_q      <= line_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.busy      = busy_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule
